reserved_parking_entry: RTL and testbench
=========================================

Name: reserved_parking_entry

Overview:
- Entry-side controller for reserved (per-flat) parking; complement of the reserved exit path.
- Owns the reserved-slot occupancy bitmap: admits a vehicle for flat F if slot F is free, marks it occupied, and drives the entry gate for a fixed time.
- Accepts exit-clear pulses from the exit side so both ends share one occupancy view.
- Reports the result of every entry request as a status code.

Parameters:
- N_SLOTS, 10, number of reserved slots; flats numbered 1..N_SLOTS.
- FW, $clog2(N_SLOTS+1), flat-number width (derived, not overridden).
- GATE_CYCLES, 4, clock cycles gate_open is held after an admit; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  entry request present.
- req_ready  out  1  block can accept a request.
- req_flat  in  FW  flat number requesting entry.
- exit_valid  in  1  one-cycle pulse: vehicle left reserved slot.
- exit_flat  in  FW  flat whose slot is vacated.
- resp_valid  out  1  one-cycle pulse: resp_code/resp_flat valid.
- resp_code  out  2  00 admitted; 01 slot already occupied; 10 invalid flat; 11 unused.
- resp_flat  out  FW  flat the response refers to.
- gate_open  out  1  entry gate open command.
- occupancy  out  N_SLOTS  bit i-1 = slot of flat i occupied.
- occupied_count  out  FW  number of set occupancy bits.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=1, resp_valid=0, resp_code=00, resp_flat=0, gate_open=0.
  - occupancy=0, occupied_count=0, gate counter=0.
- Reset asserted mid-operation aborts any CHECK/GATE. Outputs take reset values the next cycle, and a pending response is dropped.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready in cycle t, latch req_flat and go to CHECK.
  - CHECK (cycle t+1, req_ready=0):
    - flat==0 or flat>N_SLOTS: code 10, return to IDLE.
    - occupancy bit set: code 01, return to IDLE.
    - Otherwise: code 00, set the bit, load gate counter with GATE_CYCLES-1, go to GATE.
  - GATE: gate_open=1 and req_ready=0. Counter decrements each cycle; when it reaches 0, go to IDLE the next cycle.
- Response is registered:
  - resp_valid=1 for exactly cycle t+2, with resp_code and resp_flat (latched flat, even if invalid).
  - resp_code and resp_flat hold their values until the next response.
- Timing:
  - Admit: gate_open is high in cycles t+2 .. t+1+GATE_CYCLES. req_ready returns in cycle t+2+GATE_CYCLES.
  - Reject: req_ready=1 again in cycle t+2; gate_open stays 0.
- Requests arriving while req_ready=0 are not accepted. The requester holds req_valid and req_flat until the handshake.
- Exit clear:
  - Honoured in any state, including IDLE, CHECK and GATE. Clears bit exit_flat-1 at the next edge.
  - exit_flat of 0 or >N_SLOTS is ignored.
  - Clearing an already-free slot is a no-op.
- Same-cycle entry and exit:
  - CHECK evaluates occupancy as registered at the start of the cycle, before that cycle's clear.
  - If CHECK sets bit k and exit clears bit k in the same cycle, the set wins.
  - Hence an exit for flat F coincident with CHECK of flat F on an occupied slot gives code 01 and leaves the bit at 0.
- occupied_count:
  - Registered; updates in the same edge as occupancy: +1 on set, -1 on effective clear, net 0 if both.
  - It never exceeds N_SLOTS and never underflows, because sets happen only on free slots and clears only on occupied ones.

Optional Feature:
- Macro RESERVED_ENTRY_REJECT_CNT_EN.
- Defined:
  - Adds output port reject_count (16 bits), reset to 0.
  - Increments on every response with code 01 or 10.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset, then request flat 3 with GATE_CYCLES=4:
  - resp_valid at t+2 with code 00, resp_flat 3.
  - occupancy=10'b0000000100, occupied_count=1.
  - gate_open high 4 cycles; req_ready back at t+6.
- Request flat 3 again: code 01, occupancy unchanged, gate_open stays 0, req_ready back at t+2.
- Request flat 0, then flat 11 (N_SLOTS=10): both get code 10 with resp_flat 0 and 11; no state change. Optional reject_count=2 if enabled (3 counting the previous step).
- Pulse exit_valid with exit_flat=3 during GATE of a flat-5 admit:
  - bit 2 clears, bit 4 set, occupied_count stays 1.
  - A later request for flat 3 gets code 00.
- Flat 7 occupied; hold req_valid flat 7 and pulse exit flat 7 in the CHECK cycle: code 01, occupancy bit 6 ends at 0, occupied_count decrements.
- Assert rst during GATE: next cycle gate_open=0, occupancy=0, occupied_count=0, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/reserved_parking_entry.sv
// -----------------------------------------------------------------------------
// reserved_parking_entry
//
// Entry-side controller for reserved (per-flat) parking. Owns the reserved-slot
// occupancy bitmap shared with the exit side. A request for flat F is admitted
// when slot F is free: the bit is set and the entry gate is held open for
// GATE_CYCLES cycles. Exit-clear pulses from the exit side free slots in any
// state. Every request produces one registered status response.
//
// Optional feature macro: RESERVED_ENTRY_REJECT_CNT_EN
//   When defined, adds a 16-bit saturating reject_count output that counts
//   responses with code 01 (occupied) or 10 (invalid flat).
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   req_valid      in   entry request present
//   req_ready      out  block can accept a request (IDLE only)
//   req_flat       in   flat number requesting entry (1..N_SLOTS valid)
//   exit_valid     in   one-cycle pulse: vehicle left a reserved slot
//   exit_flat      in   flat whose slot is vacated
//   resp_valid     out  one-cycle pulse qualifying resp_code/resp_flat
//   resp_code      out  00 admitted, 01 occupied, 10 invalid flat
//   resp_flat      out  flat the response refers to (as latched)
//   gate_open      out  entry gate open command
//   occupancy      out  bit i-1 set = slot of flat i occupied
//   occupied_count out  number of set occupancy bits
//   reject_count   out  (optional) saturating count of rejected requests
// -----------------------------------------------------------------------------
module reserved_parking_entry #(
    parameter int N_SLOTS     = 10,
    parameter int GATE_CYCLES = 4,
    localparam int FW         = $clog2(N_SLOTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FW-1:0]      req_flat,
    input  logic               exit_valid,
    input  logic [FW-1:0]      exit_flat,
    output logic               resp_valid,
    output logic [1:0]         resp_code,
    output logic [FW-1:0]      resp_flat,
    output logic               gate_open,
    output logic [N_SLOTS-1:0] occupancy,
`ifdef RESERVED_ENTRY_REJECT_CNT_EN
    output logic [FW-1:0]      occupied_count,
    output logic [15:0]        reject_count
`else
    output logic [FW-1:0]      occupied_count
`endif
);

    localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [1:0] CODE_ADMIT   = 2'b00;
    localparam logic [1:0] CODE_BUSY    = 2'b01;
    localparam logic [1:0] CODE_INVALID = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        GATE  = 2'd2
    } state_t;

    state_t             state, next_state;
    logic [FW-1:0]      flat_q;
    logic [CW-1:0]      gate_cnt;
    logic [N_SLOTS-1:0] occ_q;
    logic [FW-1:0]      count_q;

    logic               accept;
    logic [N_SLOTS-1:0] flat_mask;
    logic [N_SLOTS-1:0] exit_mask;
    logic [N_SLOTS-1:0] set_mask;
    logic [N_SLOTS-1:0] clr_mask;
    logic               flat_ok;
    logic               slot_busy;
    logic               admit;
    logic               clr_any;
    logic [1:0]         check_code;

    assign accept = req_valid && req_ready;

    // One-hot decode of the latched flat and the exit flat. Out-of-range
    // values (0 or > N_SLOTS) decode to an all-zero mask, which is what makes
    // invalid flats fall out as "not ok" and invalid exits as no-ops.
    always_comb begin
        flat_mask = '0;
        exit_mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            flat_mask[i] = (flat_q == FW'(i + 1));
            exit_mask[i] = exit_valid && (exit_flat == FW'(i + 1));
        end
    end

    // CHECK looks at occupancy as registered at the start of the cycle, so a
    // coincident exit for the same flat does not turn a reject into an admit.
    assign flat_ok   = |flat_mask;
    assign slot_busy = |(flat_mask & occ_q);
    assign admit     = (state == CHECK) && flat_ok && !slot_busy;

    always_comb begin
        check_code = CODE_ADMIT;
        if (!flat_ok) begin
            check_code = CODE_INVALID;
        end else if (slot_busy) begin
            check_code = CODE_BUSY;
        end
    end

    // Only clears of occupied slots count. A set only ever targets a free
    // slot, so a set and a clear of the same bit cannot both be effective:
    // the set wins and the count moves by +1 only.
    assign set_mask = admit ? flat_mask : '0;
    assign clr_mask = exit_mask & occ_q;
    assign clr_any  = |clr_mask;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CHECK;
            CHECK:   next_state = admit ? GATE : IDLE;
            GATE:    if (gate_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        gate_open = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            GATE:    gate_open = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            flat_q <= '0;
        end else if (accept) begin
            flat_q <= req_flat;
        end
    end

    // Loaded with GATE_CYCLES-1 so that GATE lasts exactly GATE_CYCLES cycles
    // including the cycle in which the counter reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt <= '0;
        end else if (admit) begin
            gate_cnt <= CW'(GATE_CYCLES - 1);
        end else if (state == GATE && gate_cnt != '0) begin
            gate_cnt <= gate_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= (occ_q & ~clr_mask) | set_mask;
            count_q <= count_q + FW'(admit) - FW'(clr_any);
        end
    end

    assign occupancy      = occ_q;
    assign occupied_count = count_q;

    // Registered response; code and flat hold until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_code  <= CODE_ADMIT;
            resp_flat  <= '0;
        end else begin
            resp_valid <= (state == CHECK);
            if (state == CHECK) begin
                resp_code <= check_code;
                resp_flat <= flat_q;
            end
        end
    end

`ifdef RESERVED_ENTRY_REJECT_CNT_EN
    logic [15:0] rej_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_q <= '0;
        end else if (state == CHECK && check_code != CODE_ADMIT
                     && rej_q != 16'hFFFF) begin
            rej_q <= rej_q + 16'd1;
        end
    end

    assign reject_count = rej_q;
`endif

endmodule

// File: tb/tb_reserved_parking_entry.sv
// -----------------------------------------------------------------------------
// Self-checking bench for reserved_parking_entry. A timestamp-based model
// predicts, for every cycle, the ready/gate/response/occupancy outputs from
// the handshake cycle of each request, then directed scenarios and a long
// randomized run are compared against it.
// -----------------------------------------------------------------------------
module tb_reserved_parking_entry;

    localparam int N  = 10;
    localparam int GC = 4;
    localparam int FW = $clog2(N + 1);
    localparam int BIG = 32'h3fff_ffff;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [FW-1:0] req_flat;
    logic          exit_valid;
    logic [FW-1:0] exit_flat;
    logic          resp_valid;
    logic [1:0]    resp_code;
    logic [FW-1:0] resp_flat;
    logic          gate_open;
    logic [N-1:0]  occupancy;
    logic [FW-1:0] occupied_count;
`ifdef RESERVED_ENTRY_REJECT_CNT_EN
    logic [15:0]   reject_count;
`endif

    reserved_parking_entry #(.N_SLOTS(N), .GATE_CYCLES(GC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_flat(req_flat),
        .exit_valid(exit_valid), .exit_flat(exit_flat),
        .resp_valid(resp_valid), .resp_code(resp_code), .resp_flat(resp_flat),
        .gate_open(gate_open), .occupancy(occupancy),
`ifdef RESERVED_ENTRY_REJECT_CNT_EN
        .occupied_count(occupied_count), .reject_count(reject_count)
`else
        .occupied_count(occupied_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Model: everything is expressed as cycle numbers relative to handshakes.
    int           cyc;
    int           ready_at, gate_from, gate_to, resp_at, check_at, chk_flat;
    int           e_code, e_flat, m_cnt, m_rej;
    logic [N-1:0] m_occ;

    task automatic model_reset();
        ready_at = cyc + 1; gate_from = 0; gate_to = -1;
        resp_at = -1; check_at = -1; chk_flat = 0;
        e_code = 0; e_flat = 0; m_occ = '0; m_cnt = 0; m_rej = 0;
    endtask

    // One clock cycle: compare outputs of this cycle, drive inputs, advance
    // the model across the coming edge.
    task automatic step(input bit rv, input int rf, input bit ev, input int ef,
                        input bit r, output bit acc);
        logic [N-1:0] nocc;
        int code;
        chk("req_ready", req_ready, cyc >= ready_at);
        chk("gate_open", gate_open, cyc >= gate_from && cyc <= gate_to);
        chk("resp_valid", resp_valid, cyc == resp_at);
        chk("resp_code", resp_code, e_code);
        chk("resp_flat", resp_flat, e_flat);
        chk("occupancy", occupancy, m_occ);
        chk("occ_count", occupied_count, m_cnt);
`ifdef RESERVED_ENTRY_REJECT_CNT_EN
        chk("reject_count", reject_count, m_rej);
`endif
        rst = r; req_valid = rv; req_flat = FW'(rf);
        exit_valid = ev; exit_flat = FW'(ef);
        acc = 1'b0;
        if (r) begin
            model_reset();
        end else begin
            nocc = m_occ;
            if (cyc == check_at) begin
                if (chk_flat < 1 || chk_flat > N) code = 2;
                else if (m_occ[chk_flat-1]) code = 1;
                else code = 0;
                if (code == 0) begin
                    nocc[chk_flat-1] = 1'b1; m_cnt++;
                    gate_from = cyc + 1; gate_to = cyc + GC; ready_at = cyc + 1 + GC;
                end else begin
                    ready_at = cyc + 1;
                    if (m_rej < 16'hFFFF) m_rej++;
                end
                e_code = code; e_flat = chk_flat; resp_at = cyc + 1;
            end
            if (rv && cyc >= ready_at) begin
                acc = 1'b1; check_at = cyc + 1; chk_flat = rf; ready_at = BIG;
            end
            if (ev && ef >= 1 && ef <= N && m_occ[ef-1]) begin
                nocc[ef-1] = 1'b0; m_cnt--;
            end
            m_occ = nocc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, a);
    endtask

    // Holds the request until the handshake, bounded.
    task automatic do_req(input int f);
        bit a = 1'b0;
        for (int i = 0; i < 40 && !a; i++) step(1, f, 0, 0, 0, a);
        if (!a) chk("handshake_timeout", 0, 1);
    endtask

    initial begin
        bit a, hold_rv, ev;
        int hold_rf, ef;
        rst = 1'b1; req_valid = 1'b0; req_flat = '0;
        exit_valid = 1'b0; exit_flat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        model_reset();
        ready_at = 0;

        // Admit flat 3, explicit spot checks at t+2.
        do_req(3);
        idle(1);
        chk("admit3_valid", resp_valid, 1);
        chk("admit3_occ", occupancy, 10'b0000000100);
        chk("admit3_gate", gate_open, 1);
        idle(6);
        // Re-request flat 3: occupied.
        do_req(3); idle(3);
        // Invalid flats 0 and 11.
        do_req(0); idle(3);
        do_req(11); idle(1);
        chk("inv11_flat", resp_flat, 11);
        chk("inv11_code", resp_code, 2);
        idle(2);
        // Exit flat 3 during GATE of a flat-5 admit.
        do_req(5); idle(1);
        step(0, 0, 1, 3, 0, a);
        chk("exit3_occ", occupancy, 10'b0000010000);
        chk("exit3_cnt", occupied_count, 1);
        idle(5);
        do_req(3); idle(6);
        // Flat 7 occupied; exit 7 in the CHECK cycle of a second request.
        do_req(7); idle(6);
        do_req(7);
        step(0, 0, 1, 7, 0, a);
        chk("ex7_code", resp_code, 1);
        chk("ex7_bit", occupancy[6], 0);
        idle(3);
        // Reset during GATE.
        do_req(2); idle(2);
        chk("pre_rst_gate", gate_open, 1);
        step(0, 0, 0, 0, 1, a);
        chk("rst_gate", gate_open, 0);
        chk("rst_occ", occupancy, 0);
        idle(2);

        // Randomized traffic.
        hold_rv = 1'b0; hold_rf = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold_rv && ($urandom % 3 == 0)) begin
                hold_rv = 1'b1;
                hold_rf = ($urandom % 4 == 0) ? int'($urandom % 13) : int'($urandom_range(1, N));
            end
            ev = ($urandom % 4 == 0);
            ef = ($urandom % 2 == 0) ? int'($urandom_range(1, N)) : int'($urandom % 13);
            step(hold_rv, hold_rf, ev, ef, ($urandom % 400 == 0), a);
            if (a) hold_rv = 1'b0;
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
